alu181_pipe: RTL and testbench
==============================

// Module: alu181_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 74181-style ALU. It keeps the same 16-function S/M/CN
//  table and widens it to WIDTH bits. It adds a valid/ready handshake, 1- or 2-stage registered
//  latency, a stored carry flag for multi-word carry chaining, and a signed-overflow flag.
//  It sits between the register file and the bus/accumulator in the teaching datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
//  PIPE   1  register stages: 1 = result reg only; 2 = operand reg + result reg
// PORTS
//  CLK       in   1      clock, all state rising-edge
//  RST       in   1      asynchronous, active-high reset
//  IN_VLD    in   1      operation offered
//  IN_RDY    out  1      operation accepted when IN_VLD & IN_RDY
//  S         in   4      function select (74181 encoding)
//  M         in   1      0 = arithmetic, 1 = logic
//  CN        in   1      carry-in when CSEL=0
//  CSEL      in   1      1 = use stored carry flag CF instead of CN
//  A, B      in   WIDTH  operands
//  OUT_VLD   out  1      result valid
//  OUT_RDY   in   1      result consumed when OUT_VLD & OUT_RDY
//  F         out  WIDTH  result
//  CO        out  1      bit WIDTH of the (WIDTH+1)-bit result
//  FZ        out  1      1 = (WIDTH+1)-bit result nonzero (legacy polarity)
//  OV        out  1      signed overflow, S=1001/0110 with M=0 only, else 0
//  CF        out  1      stored carry flag
//  FLAG_CLR  in   1      synchronous clear of CF
// BEHAVIOUR
//  - Reset (async): OUT_VLD=0, F=0, CO=0, FZ=0, OV=0, CF=0, all stage valids=0.
//    In-flight operations are discarded; IN_RDY=1 after reset release.
//  - Width rule: A, B are zero-extended to WIDTH+1 bits. The result is computed mod 2^(WIDTH+1).
//    F = bits[WIDTH-1:0], CO = bit[WIDTH]. Logic ops also act on the extension bit
//    (e.g. ~A gives CO=1).
//  - Carry select: C = CSEL ? CF : CN, sampled when the result register is written, not at accept.
//  - M=0 ops: 0000 A+C; 0001 (A|B)+C; 0010 (A|~B)+C; 0011 0-C; 0100 A+(A&~B)+C;
//    0101 (A|B)+(A&~B)+C; 0110 A-B-C; 0111 (A&~B)-C; 1000 A+(A&B)+C; 1001 A+B+C;
//    1010 (A|~B)+(A&B)+C; 1011 (A&B)-C; 1100 A+A+C; 1101 (A|B)+A+C; 1110 (A|~B)+A+C; 1111 A-C.
//  - M=1 ops: 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0; 0100 ~(A&B); 0101 ~B; 0110 A^B;
//    0111 A&~B; 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B; 1100 constant 1; 1101 A|~B;
//    1110 A|B; 1111 A.
//  - OV: 1001 -> A,B same sign and F sign differs. 0110 -> A,B signs differ and F sign != A sign.
//  - CF: loaded with CO on every result-register write. FLAG_CLR=1 clears CF and wins over a
//    coincident write. The written result still uses the pre-clear CF.
//  - Handshake, PIPE=1: the result reg loads on accept. IN_RDY = !OUT_VLD | OUT_RDY.
//    OUT_VLD rises the cycle after accept. Latency 1.
//  - Handshake, PIPE=2: stage 1 holds S/M/CN/CSEL/A/B. Stage 2 is the result reg, written when
//    stage 1 is valid and (!OUT_VLD | OUT_RDY). IN_RDY = !v1 | stage-1 advancing. Latency 2.
//    Full throughput is one op per cycle.
//  - Back-to-back CSEL chains are exact: each op reads CF written by the previous op's result edge.
//  - While OUT_VLD & !OUT_RDY: F/CO/FZ/OV/CF hold stable and no stage advances into a full stage.
//  - Results leave in accept order; none are dropped or duplicated. IN_VLD is ignored while IN_RDY=0.
//  - Simultaneous accept and consume at a full pipe keeps throughput; valids stay 1.
// TESTING (WIDTH=8, both PIPE values)
//  1. S=1001 M=0 CN=1 A=FF B=00 -> F=00 CO=1 FZ=1 OV=0; CF=1 after write.
//  2. S=0011 M=0 CN=0 -> F=00 CO=0 FZ=0. S=0000 M=1 A=0F -> F=F0 CO=1.
//  3. Chain: S=1001 M=0 CN=0 A=FF B=01 -> F=00 CO=1. Next op CSEL=1 A=00 B=00 -> F=01 CO=0, CF=0.
//  4. S=0110 M=0 CN=0 A=80 B=01 -> F=7F CO=0 OV=1. A=05 B=07 -> F=FE CO=1 OV=0.
//  5. PIPE=2, OUT_RDY=0 for 4 cycles, IN_VLD=1 with 3 ops -> 2 accepted, IN_RDY=0, F stable.
//     Release OUT_RDY -> 3 results in order on consecutive cycles.
//  6. RST pulsed mid-cycle with an op in stage 1 -> OUT_VLD=0 and CF=0 immediately.
//     No stale result appears after release. FLAG_CLR coincident with a CO=1 write -> CF=0.

Source files
------------

// File: rtl/alu181_pipe.sv
// Pipelined 74181-style ALU: WIDTH-bit operands, 16-function S/M table, valid/ready
// handshake with 1 or 2 register stages, stored carry flag for multi-word chains.
//
// State held                | meaning
// v1_q                      | stage 1 holds an accepted op (PIPE=2 only)
// out_vld_q                 | result register holds an unconsumed result
// cf_q                      | carry of the most recent result write
module alu181_pipe #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VLD,
    output logic             IN_RDY,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             CN,
    input  logic             CSEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VLD,
    input  logic             OUT_RDY,
    output logic [WIDTH-1:0] F,
    output logic             CO,
    output logic             FZ,
    output logic             OV,
    output logic             CF,
    input  logic             FLAG_CLR
);

    localparam int XW = WIDTH + 1;

    logic             v1_q, v1_d;
    logic [3:0]       s1_s_q, s1_s_d;
    logic             s1_m_q, s1_m_d, s1_cn_q, s1_cn_d, s1_csel_q, s1_csel_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;

    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             co_q, co_d, fz_q, fz_d, ov_q, ov_d, cf_q, cf_d;

    logic             out_free, res_wr, in_rdy, accept;
    logic [3:0]       op_s;
    logic             op_m, op_cn, op_csel, c_in, ov_x;
    logic [WIDTH-1:0] op_a, op_b;
    logic [XW-1:0]    xa, xb, cx, res_x;

    // Handshake: result register write enable and input acceptance per pipeline depth
    always_comb begin
        out_free = !out_vld_q || OUT_RDY;
        res_wr   = 1'b0;
        in_rdy   = 1'b0;
        if (PIPE == 2) begin
            res_wr = v1_q && out_free;
            in_rdy = !v1_q || res_wr;
        end else begin
            in_rdy = out_free;
            res_wr = IN_VLD && out_free;
        end
        accept = IN_VLD && in_rdy;
    end

    // Operand source: stage-1 registers for PIPE=2, live inputs otherwise
    always_comb begin
        op_s    = (PIPE == 2) ? s1_s_q    : S;
        op_m    = (PIPE == 2) ? s1_m_q    : M;
        op_cn   = (PIPE == 2) ? s1_cn_q   : CN;
        op_csel = (PIPE == 2) ? s1_csel_q : CSEL;
        op_a    = (PIPE == 2) ? s1_a_q    : A;
        op_b    = (PIPE == 2) ? s1_b_q    : B;
    end

    // ALU core on zero-extended operands; carry is chosen at result-write time
    always_comb begin
        xa    = {1'b0, op_a};
        xb    = {1'b0, op_b};
        c_in  = op_csel ? cf_q : op_cn;
        cx    = {{WIDTH{1'b0}}, c_in};
        res_x = '0;
        if (!op_m) begin
            case (op_s)
                4'b0000: res_x = xa + cx;
                4'b0001: res_x = (xa | xb) + cx;
                4'b0010: res_x = (xa | ~xb) + cx;
                4'b0011: res_x = {XW{1'b0}} - cx;
                4'b0100: res_x = xa + (xa & ~xb) + cx;
                4'b0101: res_x = (xa | xb) + (xa & ~xb) + cx;
                4'b0110: res_x = xa - xb - cx;
                4'b0111: res_x = (xa & ~xb) - cx;
                4'b1000: res_x = xa + (xa & xb) + cx;
                4'b1001: res_x = xa + xb + cx;
                4'b1010: res_x = (xa | ~xb) + (xa & xb) + cx;
                4'b1011: res_x = (xa & xb) - cx;
                4'b1100: res_x = xa + xa + cx;
                4'b1101: res_x = (xa | xb) + xa + cx;
                4'b1110: res_x = (xa | ~xb) + xa + cx;
                4'b1111: res_x = xa - cx;
                default: res_x = '0;
            endcase
        end else begin
            case (op_s)
                4'b0000: res_x = ~xa;
                4'b0001: res_x = ~(xa | xb);
                4'b0010: res_x = ~xa & xb;
                4'b0011: res_x = '0;
                4'b0100: res_x = ~(xa & xb);
                4'b0101: res_x = ~xb;
                4'b0110: res_x = xa ^ xb;
                4'b0111: res_x = xa & ~xb;
                4'b1000: res_x = ~xa | xb;
                4'b1001: res_x = ~(xa ^ xb);
                4'b1010: res_x = xb;
                4'b1011: res_x = xa & xb;
                4'b1100: res_x = '1;
                4'b1101: res_x = xa | ~xb;
                4'b1110: res_x = xa | xb;
                4'b1111: res_x = xa;
                default: res_x = '0;
            endcase
        end
        ov_x = 1'b0;
        if (!op_m && op_s == 4'b1001)
            ov_x = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res_x[WIDTH-1] != op_a[WIDTH-1]);
        else if (!op_m && op_s == 4'b0110)
            ov_x = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res_x[WIDTH-1] != op_a[WIDTH-1]);
    end

    // Stage-1 next state: load on accept, empty when it advances without a refill
    always_comb begin
        v1_d      = v1_q;
        s1_s_d    = s1_s_q;
        s1_m_d    = s1_m_q;
        s1_cn_d   = s1_cn_q;
        s1_csel_d = s1_csel_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        if (PIPE == 2) begin
            if (accept) begin
                v1_d      = 1'b1;
                s1_s_d    = S;
                s1_m_d    = M;
                s1_cn_d   = CN;
                s1_csel_d = CSEL;
                s1_a_d    = A;
                s1_b_d    = B;
            end else if (res_wr) begin
                v1_d = 1'b0;
            end
        end
    end

    // Result stage next state; FLAG_CLR overrides the carry load but not the result itself
    always_comb begin
        out_vld_d = out_vld_q;
        f_d       = f_q;
        co_d      = co_q;
        fz_d      = fz_q;
        ov_d      = ov_q;
        if (res_wr) begin
            out_vld_d = 1'b1;
            f_d       = res_x[WIDTH-1:0];
            co_d      = res_x[WIDTH];
            fz_d      = |res_x;
            ov_d      = ov_x;
        end else if (OUT_RDY) begin
            out_vld_d = 1'b0;
        end
        if (FLAG_CLR)
            cf_d = 1'b0;
        else if (res_wr)
            cf_d = res_x[WIDTH];
        else
            cf_d = cf_q;
    end

    // State registers, cleared asynchronously so in-flight work is discarded
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q      <= 1'b0;
            s1_s_q    <= '0;
            s1_m_q    <= 1'b0;
            s1_cn_q   <= 1'b0;
            s1_csel_q <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            out_vld_q <= 1'b0;
            f_q       <= '0;
            co_q      <= 1'b0;
            fz_q      <= 1'b0;
            ov_q      <= 1'b0;
            cf_q      <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            s1_s_q    <= s1_s_d;
            s1_m_q    <= s1_m_d;
            s1_cn_q   <= s1_cn_d;
            s1_csel_q <= s1_csel_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            out_vld_q <= out_vld_d;
            f_q       <= f_d;
            co_q      <= co_d;
            fz_q      <= fz_d;
            ov_q      <= ov_d;
            cf_q      <= cf_d;
        end
    end

    assign IN_RDY  = in_rdy;
    assign OUT_VLD = out_vld_q;
    assign F       = f_q;
    assign CO      = co_q;
    assign FZ      = fz_q;
    assign OV      = ov_q;
    assign CF      = cf_q;

endmodule

// File: tb/tb_alu181_pipe.sv
// Scoreboard bench for alu181_pipe: one PIPE=1 and one PIPE=2 instance share data inputs,
// the suite is run against each in turn; expected results are queued at accept.
module tb_alu181_pipe;

    typedef struct packed {
        logic [7:0] f;
        logic       co;
        logic       fz;
        logic       ov;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       sel, in_vld, out_rdy, flag_clr;
    logic [3:0] s;
    logic       m, cn, csel;
    logic [7:0] a, b;

    logic       vld1, vld2, rdy1, rdy2, ovld1, ovld2;
    logic [7:0] f1, f2;
    logic       co1, co2, fz1, fz2, ov1, ov2, cf1, cf2;
    logic       cur_rdy, cur_ovld, cur_cf;
    logic [7:0] cur_f;

    exp_t q1[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;
    int   pops1 = 0;
    int   pops2 = 0;

    always #5 CLK = ~CLK;

    assign vld1     = in_vld & ~sel;
    assign vld2     = in_vld & sel;
    assign cur_rdy  = sel ? rdy2 : rdy1;
    assign cur_ovld = sel ? ovld2 : ovld1;
    assign cur_cf   = sel ? cf2 : cf1;
    assign cur_f    = sel ? f2 : f1;

    alu181_pipe #(.WIDTH(8), .PIPE(1)) u_p1 (
        .CLK(CLK), .RST(RST), .IN_VLD(vld1), .IN_RDY(rdy1), .S(s), .M(m), .CN(cn),
        .CSEL(csel), .A(a), .B(b), .OUT_VLD(ovld1), .OUT_RDY(out_rdy), .F(f1), .CO(co1),
        .FZ(fz1), .OV(ov1), .CF(cf1), .FLAG_CLR(flag_clr)
    );

    alu181_pipe #(.WIDTH(8), .PIPE(2)) u_p2 (
        .CLK(CLK), .RST(RST), .IN_VLD(vld2), .IN_RDY(rdy2), .S(s), .M(m), .CN(cn),
        .CSEL(csel), .A(a), .B(b), .OUT_VLD(ovld2), .OUT_RDY(out_rdy), .F(f2), .CO(co2),
        .FZ(fz2), .OV(ov2), .CF(cf2), .FLAG_CLR(flag_clr)
    );

    // Monitor for the PIPE=1 instance: pop and compare on every consumed result
    always @(negedge CLK) begin : mon1
        exp_t got, e;
        if (!RST && ovld1 && out_rdy) begin
            got = {f1, co1, fz1, ov1};
            checks++;
            pops1++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL p1_unexpected: got F=%h CO=%b FZ=%b OV=%b, no result expected", f1, co1, fz1, ov1);
            end else begin
                e = q1.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL p1_result: got F=%h CO=%b FZ=%b OV=%b, expected F=%h CO=%b FZ=%b OV=%b",
                             got.f, got.co, got.fz, got.ov, e.f, e.co, e.fz, e.ov);
                end
            end
        end
    end

    // Monitor for the PIPE=2 instance
    always @(negedge CLK) begin : mon2
        exp_t got, e;
        if (!RST && ovld2 && out_rdy) begin
            got = {f2, co2, fz2, ov2};
            checks++;
            pops2++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL p2_unexpected: got F=%h CO=%b FZ=%b OV=%b, no result expected", f2, co2, fz2, ov2);
            end else begin
                e = q2.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL p2_result: got F=%h CO=%b FZ=%b OV=%b, expected F=%h CO=%b FZ=%b OV=%b",
                             got.f, got.co, got.fz, got.ov, e.f, e.co, e.fz, e.ov);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL p%0d_%s: got %0h expected %0h", sel + 1, name, act, exp);
        end
    endtask

    task automatic push(input exp_t e);
        if (sel) q2.push_back(e);
        else     q1.push_back(e);
    endtask

    task automatic issue(input logic [3:0] ts, input logic tm, input logic tcn, input logic tcsel,
                         input logic [7:0] ta, input logic [7:0] tbv,
                         input logic [7:0] ef, input logic eco, input logic efz, input logic eov);
        int n;
        s = ts; m = tm; cn = tcn; csel = tcsel; a = ta; b = tbv;
        in_vld = 1'b1;
        @(negedge CLK);
        n = 0;
        while (!cur_rdy && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!cur_rdy) begin
            checks++;
            errors++;
            $display("FAIL p%0d_accept_timeout: IN_RDY stayed 0 for S=%b A=%h B=%h", sel + 1, ts, ta, tbv);
        end else begin
            push({ef, eco, efz, eov});
        end
        @(posedge CLK);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (((sel ? q2.size() : q1.size()) != 0 || cur_ovld) && n < 30) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL p%0d_drain_timeout: got %0d pending results, expected 0", sel + 1,
                     sel ? q2.size() : q1.size());
        end
    endtask

    task automatic do_reset();
        in_vld = 1'b0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic run_suite();
        exp_t       e5[3];
        logic [7:0] a5[3];
        logic [7:0] b5[3];
        int         idx, p0;

        do_reset();
        chk("rst_out_vld", cur_ovld, 0);
        chk("rst_f", cur_f, 0);
        chk("rst_cf", cur_cf, 0);
        chk("rst_in_rdy", cur_rdy, 1);

        issue(4'b1001, 0, 1, 0, 8'hFF, 8'h00, 8'h00, 1, 1, 0);
        drain();
        chk("add_cf", cur_cf, 1);
        issue(4'b0011, 0, 0, 0, 8'h5A, 8'hA5, 8'h00, 0, 0, 0);
        issue(4'b0000, 1, 0, 0, 8'h0F, 8'h00, 8'hF0, 1, 1, 0);
        issue(4'b1001, 0, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
        issue(4'b1001, 0, 0, 1, 8'h00, 8'h00, 8'h01, 0, 1, 0);
        drain();
        chk("chain_cf", cur_cf, 0);
        issue(4'b0110, 0, 0, 0, 8'h80, 8'h01, 8'h7F, 0, 1, 1);
        issue(4'b0110, 0, 0, 0, 8'h05, 8'h07, 8'hFE, 1, 1, 0);
        issue(4'b0110, 0, 1, 0, 8'h10, 8'h05, 8'h0A, 0, 1, 0);
        issue(4'b0111, 0, 0, 0, 8'hF0, 8'h30, 8'hC0, 0, 1, 0);
        issue(4'b1100, 0, 0, 0, 8'h80, 8'h00, 8'h00, 1, 1, 0);
        issue(4'b1111, 0, 1, 0, 8'h00, 8'h00, 8'hFF, 1, 1, 0);
        issue(4'b0110, 1, 0, 0, 8'h3C, 8'h0F, 8'h33, 0, 1, 0);
        issue(4'b1100, 1, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 1, 0);
        issue(4'b0101, 1, 0, 0, 8'h00, 8'hFF, 8'h00, 1, 1, 0);
        drain();

        // Back-pressure: stall the consumer for 4 cycles with 3 ops on offer
        a5[0] = 8'h01; b5[0] = 8'h02; e5[0] = {8'h03, 1'b0, 1'b1, 1'b0};
        a5[1] = 8'h10; b5[1] = 8'h20; e5[1] = {8'h30, 1'b0, 1'b1, 1'b0};
        a5[2] = 8'h7F; b5[2] = 8'h01; e5[2] = {8'h80, 1'b0, 1'b1, 1'b1};
        s = 4'b1001; m = 1'b0; cn = 1'b0; csel = 1'b0;
        out_rdy = 1'b0;
        idx = 0;
        p0 = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 4) begin
                out_rdy = 1'b1;
                p0 = sel ? pops2 : pops1;
            end
            if (idx < 3) begin
                a = a5[idx];
                b = b5[idx];
                in_vld = 1'b1;
            end else begin
                in_vld = 1'b0;
            end
            @(negedge CLK);
            if (c == 3) begin
                chk("bp_accepted", idx, sel ? 2 : 1);
                chk("bp_in_rdy", cur_rdy, 0);
                chk("bp_out_vld", cur_ovld, 1);
                chk("bp_f_held", cur_f, 8'h03);
            end
            if (in_vld && cur_rdy && idx < 3) begin
                push(e5[idx]);
                idx++;
            end
            @(posedge CLK);
            #1;
        end
        in_vld = 1'b0;
        chk("bp_burst_len", (sel ? pops2 : pops1) - p0, 3);
        drain();

        // Reset in the middle of a cycle with an op in flight
        s = 4'b1001; m = 1'b0; cn = 1'b0; csel = 1'b0; a = 8'hFF; b = 8'h01;
        in_vld = 1'b1;
        @(negedge CLK);
        chk("rs_accept", cur_rdy, 1);
        @(posedge CLK);
        #1;
        in_vld = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("rs_out_vld", cur_ovld, 0);
        chk("rs_cf", cur_cf, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("rs_no_stale", cur_ovld, 0);
        chk("rs_in_rdy", cur_rdy, 1);

        // FLAG_CLR on the same edge as a CO=1 write that itself consumes CF=1
        issue(4'b1001, 0, 0, 0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);
        drain();
        chk("fc_pre_cf", cur_cf, 1);
        s = 4'b1001; m = 1'b0; cn = 1'b0; csel = 1'b1; a = 8'hFF; b = 8'h00;
        in_vld = 1'b1;
        flag_clr = ~sel;
        @(negedge CLK);
        chk("fc_accept", cur_rdy, 1);
        push({8'h00, 1'b1, 1'b1, 1'b0});
        @(posedge CLK);
        #1;
        in_vld = 1'b0;
        flag_clr = sel;
        @(posedge CLK);
        #1;
        flag_clr = 1'b0;
        drain();
        chk("fc_cf", cur_cf, 0);
    endtask

    initial begin
        RST = 1'b1;
        sel = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        flag_clr = 1'b0;
        s = 4'b0000; m = 1'b0; cn = 1'b0; csel = 1'b0; a = 8'h00; b = 8'h00;
        for (int p = 0; p < 2; p++) begin
            sel = p[0];
            run_suite();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
